// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, error-cause bit positions,
// the default ID word and the latched-request record used by the slave.
package apb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int ERR_W     = 3;
    localparam int ERR_ALIGN = 0;
    localparam int ERR_RANGE = 1;
    localparam int ERR_RO    = 2;

    localparam logic [31:0] APB_DEFAULT_ID = 32'hA5B0_0001;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } apb_req_t;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                merged[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage for the APB slave: byte-strobed write port and a
// combinational read port; index 0 reads as the ID word and is never written.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] ID_VALUE = APB_DEFAULT_ID
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [7:0]  idx,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [31:0]      mem_r [NUM_REGS];
    logic             idx_ok_s;
    logic [IDX_W-1:0] sel_s;

    // Index qualification shared by both ports.
    always_comb begin
        idx_ok_s = ({24'd0, idx} < 32'(NUM_REGS));
        sel_s    = idx[IDX_W-1:0];
    end

    // Storage update; entry 0 is shadowed by the ID word and stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (we && idx_ok_s && (idx != 8'd0)) begin
            mem_r[sel_s] <= strb_merge(mem_r[sel_s], wdata, wstrb);
        end
    end

    // Read port.
    always_comb begin
        rdata = 32'd0;
        if (idx == 8'd0) begin
            rdata = ID_VALUE;
        end else if (idx_ok_s) begin
            rdata = mem_r[sel_s];
        end else begin
            rdata = 32'd0;
        end
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave register file: latches the setup phase, inserts 1+EXTRA_WAIT wait
// states, then answers for one cycle with registered PREADY/PSLVERR/PRDATA.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int          NUM_REGS   = 16,
    parameter int          EXTRA_WAIT = 0,
    parameter logic [31:0] ID_VALUE   = APB_DEFAULT_ID
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam logic [3:0] WAIT_LOAD = 4'(EXTRA_WAIT);

    logic [1:0]       state_r;
    logic [3:0]       cnt_r;
    apb_req_t         req_r;
    logic [ERR_W-1:0] err_s;
    logic             complete_s;
    logic             bank_we_s;
    logic [31:0]      bank_rdata_s;

    // Error decode works only on the latched request.
    always_comb begin
        err_s            = '0;
        err_s[ERR_ALIGN] = (req_r.addr[1:0] != 2'b00);
        err_s[ERR_RANGE] = ({2'b00, req_r.addr[31:2]} >= 32'(NUM_REGS));
        err_s[ERR_RO]    = req_r.write && (req_r.addr[31:2] == 30'd0);
    end

    // The write lands on the same edge that raises PREADY.
    always_comb begin
        complete_s = (state_r == ST_WAIT) && PSEL && (cnt_r == 4'd0);
        bank_we_s  = complete_s && req_r.write && (err_s == '0);
    end

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (bank_we_s),
        .idx   (req_r.addr[9:2]),
        .wdata (req_r.wdata),
        .wstrb (req_r.strb),
        .rdata (bank_rdata_s)
    );

    // Transfer FSM with wait counter and registered response.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            req_r   <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        req_r.write <= PWRITE;
                        req_r.addr  <= PADDR;
                        req_r.wdata <= PWDATA;
                        req_r.strb  <= PSTRB;
                        cnt_r       <= WAIT_LOAD;
                        state_r     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!PSEL) begin
                        state_r <= ST_IDLE;
                    end else if (cnt_r == 4'd0) begin
                        state_r <= ST_DONE;
                        PREADY  <= 1'b1;
                        PSLVERR <= (err_s != '0);
                        if ((err_s != '0) || req_r.write) begin
                            PRDATA <= 32'd0;
                        end else begin
                            PRDATA <= bank_rdata_s;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= 32'd0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Self-checking bench: two slaves (EXTRA_WAIT 0 and 3) on a shared APB bus,
// table-driven transfers with a scoreboard plus hand-written corner sequences.
module tb_apb_regfile_slave;

    localparam int EW0  = 0;
    localparam int EW3  = 3;
    localparam int LAT0 = EW0 + 2;
    localparam int LAT3 = EW3 + 2;
    localparam int NV   = 21;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel0, psel3, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;

    always #5 pclk = ~pclk;

    apb_regfile_slave #(.NUM_REGS(16), .EXTRA_WAIT(EW0), .ID_VALUE(32'hA5B0_0001)) dut0 (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

    apb_regfile_slave #(.NUM_REGS(16), .EXTRA_WAIT(EW3), .ID_VALUE(32'hA5B0_0001)) dut3 (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3));

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        chk_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rdata;
        int          lat;
    } exp_t;

    vec_t vt [NV];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sample(input int d, output logic [31:0] rd, output logic rdy, output logic er);
        if (d == 0) begin
            rd = prdata0; rdy = pready0; er = pslverr0;
        end else begin
            rd = prdata3; rdy = pready3; er = pslverr3;
        end
    endtask

    task automatic push_exp(input logic [31:0] rd, input logic er, input logic chk, input int lat);
        exp_t e;
        e.rdata = rd; e.err = er; e.chk_rdata = chk; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic bus_idle();
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    // One complete transfer; returns just after the DONE-exit edge with the bus still selected.
    task automatic xfer(input string tag, input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input bit scramble);
        logic [31:0] rd;
        logic        rdy, er;
        int          cyc;
        exp_t        e;
        if (d == 0) psel0 = 1'b1; else psel3 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        if (scramble) begin
            paddr = addr ^ 32'h0000_0008; pwdata = ~data; pstrb = ~strb; pwrite = ~wr;
        end
        cyc = 1;
        sample(d, rd, rdy, er);
        check({tag, "_first_access_pready"}, {31'd0, rdy}, 32'd0);
        while (!rdy && cyc < 40) begin
            @(posedge pclk); #1;
            cyc++;
            sample(d, rd, rdy, er);
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no PREADY after %0d cycles, required PREADY=1", tag, cyc);
        end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_scoreboard: got empty queue, required one entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
            check({tag, "_pslverr"}, {31'd0, er}, {31'd0, e.err});
            if (e.chk_rdata) check({tag, "_prdata"}, rd, e.rdata);
        end
        @(posedge pclk); #1;
        sample(d, rd, rdy, er);
        check({tag, "_pready_drop"}, {31'd0, rdy}, 32'd0);
        check({tag, "_pslverr_drop"}, {31'd0, er}, 32'd0);
    endtask

    task automatic set_vec(input int i, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err,
                           input logic chk);
        vt[i].wr = wr; vt[i].addr = addr; vt[i].data = data; vt[i].strb = strb;
        vt[i].exp_rdata = exp_rdata; vt[i].exp_err = exp_err; vt[i].chk_rdata = chk;
    endtask

    initial begin
        logic [31:0] rd;
        logic        rdy, er;
        int          cyc;
        logic        seen;

        set_vec(0,  1'b1, 32'h0000_0004, 32'h1234_5678, 4'b1111, 32'h0,          1'b0, 1'b0);
        set_vec(1,  1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'h1234_5678,  1'b0, 1'b1);
        set_vec(2,  1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'b0101, 32'h0,          1'b0, 1'b0);
        set_vec(3,  1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'h12FF_56FF,  1'b0, 1'b1);
        set_vec(4,  1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, 32'h0,          1'b1, 1'b1);
        set_vec(5,  1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'b1111, 32'h0,          1'b1, 1'b1);
        set_vec(6,  1'b0, 32'h0000_0006, 32'h0,         4'b0000, 32'h0,          1'b1, 1'b1);
        set_vec(7,  1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'h12FF_56FF,  1'b0, 1'b1);
        set_vec(8,  1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'hA5B0_0001,  1'b0, 1'b1);
        set_vec(9,  1'b1, 32'h0000_003C, 32'hCAFE_BABE, 4'b1111, 32'h0,          1'b0, 1'b0);
        set_vec(10, 1'b0, 32'h0000_003C, 32'h0,         4'b0000, 32'hCAFE_BABE,  1'b0, 1'b1);
        set_vec(11, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'b0000, 32'h0,          1'b0, 1'b0);
        set_vec(12, 1'b0, 32'h0000_0008, 32'h0,         4'b0000, 32'h0,          1'b0, 1'b1);
        set_vec(13, 1'b1, 32'h4100_0004, 32'h0101_0101, 4'b1111, 32'h0,          1'b1, 1'b1);
        set_vec(14, 1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'h12FF_56FF,  1'b0, 1'b1);
        set_vec(15, 1'b0, 32'h0000_0040, 32'h0,         4'b0000, 32'h0,          1'b1, 1'b1);
        set_vec(16, 1'b1, 32'h0000_000A, 32'h0000_0001, 4'b1111, 32'h0,          1'b1, 1'b1);
        set_vec(17, 1'b0, 32'h0000_0008, 32'h0,         4'b0000, 32'h0,          1'b0, 1'b1);
        set_vec(18, 1'b1, 32'h0000_0008, 32'hA1B2_C3D4, 4'b1000, 32'h0,          1'b0, 1'b0);
        set_vec(19, 1'b0, 32'h0000_0008, 32'h0,         4'b0000, 32'hA100_0000,  1'b0, 1'b1);
        set_vec(20, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 32'h0,          1'b1, 1'b1);

        preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0; pstrb = 4'd0;
        @(posedge pclk); @(posedge pclk); #1;
        check("reset_prdata0",  prdata0,           32'd0);
        check("reset_pready0",  {31'd0, pready0},  32'd0);
        check("reset_pslverr0", {31'd0, pslverr0}, 32'd0);
        check("reset_prdata3",  prdata3,           32'd0);
        check("reset_pready3",  {31'd0, pready3},  32'd0);
        check("reset_pslverr3", {31'd0, pslverr3}, 32'd0);
        preset = 1'b0;
        bus_idle();

        // Reset in the middle of a slow write to index 1.
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        preset = 1'b1;
        #1;
        check("midwait_rst_prdata",  prdata3,           32'd0);
        check("midwait_rst_pready",  {31'd0, pready3},  32'd0);
        check("midwait_rst_pslverr", {31'd0, pslverr3}, 32'd0);
        psel3 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        bus_idle();
        push_exp(32'h0, 1'b0, 1'b1, LAT3);
        xfer("midwait_rst_readback", 3, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
        bus_idle();

        // Table: back-to-back transfers on the zero-extra-wait slave.
        for (int i = 0; i < NV; i++) begin
            push_exp(vt[i].exp_rdata, vt[i].exp_err, vt[i].chk_rdata, LAT0);
            xfer($sformatf("vec%0d", i), 0, vt[i].wr, vt[i].addr, vt[i].data, vt[i].strb, 1'b0);
        end
        bus_idle();

        // Bus changes after setup must not affect the latched transfer.
        push_exp(32'h0, 1'b0, 1'b0, LAT0);
        xfer("latched_write", 0, 1'b1, 32'h0000_000C, 32'h5A5A_5A5A, 4'hF, 1'b1);
        push_exp(32'h5A5A_5A5A, 1'b0, 1'b1, LAT0);
        xfer("latched_rb_c", 0, 1'b0, 32'h0000_000C, 32'h0, 4'h0, 1'b0);
        push_exp(32'h12FF_56FF, 1'b0, 1'b1, LAT0);
        xfer("latched_rb_4", 0, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 1'b0);
        bus_idle();

        // Slow slave: ID read with three extra wait states.
        push_exp(32'hA5B0_0001, 1'b0, 1'b1, LAT3);
        xfer("ew3_id", 3, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        push_exp(32'h0, 1'b0, 1'b0, LAT3);
        xfer("ew3_wr", 3, 1'b1, 32'h8, 32'h0000_00AA, 4'hF, 1'b0);
        bus_idle();

        // Abort: PSEL dropped during WAIT.
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h1111_1111; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel3 = 1'b0; penable = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge pclk); #1;
            if (pready3) seen = 1'b1;
        end
        check("abort_no_pready", {31'd0, seen}, 32'd0);
        push_exp(32'h0000_00AA, 1'b0, 1'b1, LAT3);
        xfer("abort_readback", 3, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
        bus_idle();

        // Reset while the response is being presented.
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 1;
        while (!pready3 && cyc < 40) begin
            @(posedge pclk); #1;
            cyc++;
        end
        check("done_rst_pready_before", {31'd0, pready3}, 32'd1);
        preset = 1'b1;
        #1;
        check("done_rst_prdata", prdata3,           32'd0);
        check("done_rst_pready", {31'd0, pready3},  32'd0);
        psel3 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        bus_idle();
        push_exp(32'h0, 1'b0, 1'b1, LAT0);
        xfer("post_rst_reg1", 0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
        push_exp(32'hA5B0_0001, 1'b0, 1'b1, LAT0);
        xfer("post_rst_id", 0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        bus_idle();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
